// File: rtl/tl45_pkg.sv
// rtl/tl45_pkg.sv - shared TL45 opcodes, MDU state encoding and divide constants
package tl45_pkg;

   // Execute-stage opcodes shared by the ALU and the MDU.
   localparam logic [4:0] OP_NOP  = 5'h00;
   localparam logic [4:0] OP_ADD  = 5'h01;
   localparam logic [4:0] OP_SUB  = 5'h02;
   localparam logic [4:0] OP_MUL  = 5'h03;
   localparam logic [4:0] OP_DIVU = 5'h04;
   localparam logic [4:0] OP_AND  = 5'h05;
   localparam logic [4:0] OP_OR   = 5'h06;
   localparam logic [4:0] OP_XOR  = 5'h07;
   localparam logic [4:0] OP_REMU = 5'h0F;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_BUSY = 2'd1,
      MDU_DONE = 2'd2
   } mdu_state_e;

   // Quotient reported for a zero divisor; no trap is raised.
   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/tl45_mdu_if.sv
// rtl/tl45_mdu_if.sv - decode/execute buffer and writeback signals of the TL45 MDU
interface tl45_mdu_if;
   logic        i_pipe_stall;
   logic        o_pipe_stall;
   logic        i_pipe_flush;
   logic        o_pipe_flush;
   logic [4:0]  i_opcode;
   logic [3:0]  i_dr;
   logic [31:0] i_sr1_val;
   logic [31:0] i_sr2_val;
   logic [3:0]  o_dr;
   logic [31:0] o_value;
   logic [3:0]  o_of_reg;
   logic [31:0] o_of_val;
   logic        o_busy;

   // Pipeline side: drives the buffered instruction, observes writeback.
   modport master (
      output i_pipe_stall, i_pipe_flush, i_opcode, i_dr, i_sr1_val, i_sr2_val,
      input  o_pipe_stall, o_pipe_flush, o_dr, o_value, o_of_reg, o_of_val, o_busy
   );

   // MDU side.
   modport slave (
      input  i_pipe_stall, i_pipe_flush, i_opcode, i_dr, i_sr1_val, i_sr2_val,
      output o_pipe_stall, o_pipe_flush, o_dr, o_value, o_of_reg, o_of_val, o_busy
   );
endinterface

// File: rtl/tl45_mdu_iter.sv
// rtl/tl45_mdu_iter.sv - one-bit-per-cycle shift-add / restoring-divide datapath (divider under TL45_MDU_DIV_EN)
module tl45_mdu_iter
   import tl45_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        start,
   input  logic        step,
   input  logic        op_is_div,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] nxt_prod
`ifdef TL45_MDU_DIV_EN
   ,
   output logic [31:0] nxt_quo,
   output logic [31:0] nxt_rem
`endif
);

   // a_sh: multiplicand shifting left (MUL) or dividend turning into quotient (DIV)
   // b_sh: multiplier shifting right (MUL) or the held divisor (DIV)
   logic [31:0] a_sh, b_sh, acc;
   logic [31:0] a_sh_n, b_sh_n, acc_n;
`ifdef TL45_MDU_DIV_EN
   logic [32:0] rem, rem_n, shifted;
`endif

   // Next state of one iteration; the top registers the post-step result on the final edge.
   always_comb begin
      acc_n  = acc;
      a_sh_n = a_sh;
      b_sh_n = b_sh;
      if (!op_is_div) begin
         acc_n  = b_sh[0] ? (acc + a_sh) : acc;
         a_sh_n = {a_sh[30:0], 1'b0};
         b_sh_n = {1'b0, b_sh[31:1]};
      end
`ifdef TL45_MDU_DIV_EN
      rem_n   = rem;
      shifted = {rem[31:0], a_sh[31]};
      if (op_is_div) begin
         // rem[32] set would already exceed any 32-bit divisor
         if (rem[32] || (shifted >= {1'b0, b_sh})) begin
            rem_n  = shifted - {1'b0, b_sh};
            a_sh_n = {a_sh[30:0], 1'b1};
         end else begin
            rem_n  = shifted;
            a_sh_n = {a_sh[30:0], 1'b0};
         end
      end
`endif
   end

   assign nxt_prod = acc_n;
`ifdef TL45_MDU_DIV_EN
   assign nxt_quo  = (b_sh == 32'd0) ? DIV_ZERO_Q : a_sh_n;
   assign nxt_rem  = rem_n[31:0];
`endif

   // Load operands on start, advance one bit per step, drop everything on reset or flush.
   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         a_sh <= '0;
         b_sh <= '0;
         acc  <= '0;
`ifdef TL45_MDU_DIV_EN
         rem  <= '0;
`endif
      end else if (start) begin
         a_sh <= a;
         b_sh <= b;
         acc  <= '0;
`ifdef TL45_MDU_DIV_EN
         rem  <= '0;
`endif
      end else if (step) begin
         a_sh <= a_sh_n;
         b_sh <= b_sh_n;
         acc  <= acc_n;
`ifdef TL45_MDU_DIV_EN
         rem  <= rem_n;
`endif
      end
   end

endmodule

// File: rtl/tl45_mdu.sv
// rtl/tl45_mdu.sv - TL45 iterative multiply/divide unit, DIVU/REMU enabled by TL45_MDU_DIV_EN
module tl45_mdu
   import tl45_pkg::*;
#(
   parameter int ITERS = 32
)
(
   input logic       i_clk,
   input logic       i_reset_n,
   tl45_mdu_if.slave bus
);

   localparam logic [1:0] S_IDLE = MDU_IDLE;
   localparam logic [1:0] S_BUSY = MDU_BUSY;
   localparam logic [1:0] S_DONE = MDU_DONE;
   localparam logic [4:0] LAST   = 5'(ITERS - 1);

   logic [1:0]  state;
   logic [4:0]  cnt;
   logic [4:0]  op_q;
   logic [3:0]  dr_q;
   logic [3:0]  wb_dr;
   logic [31:0] wb_val;
   logic        is_mdu_op, mdu_busy, start, op_is_div;
   logic [31:0] nxt_prod, result;
`ifdef TL45_MDU_DIV_EN
   logic [31:0] nxt_quo, nxt_rem;

   assign is_mdu_op = (bus.i_opcode == OP_MUL) || (bus.i_opcode == OP_DIVU) ||
                      (bus.i_opcode == OP_REMU);
`else
   assign is_mdu_op = (bus.i_opcode == OP_MUL);
`endif

   assign start     = (state == S_IDLE) && is_mdu_op && !bus.i_pipe_flush;
   assign mdu_busy  = start || (state == S_BUSY);
   assign op_is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);

   assign bus.o_pipe_stall = bus.i_pipe_stall || mdu_busy;
   assign bus.o_pipe_flush = bus.i_pipe_flush;
   assign bus.o_dr         = wb_dr;
   assign bus.o_value      = wb_val;
   assign bus.o_busy       = (state != S_IDLE);
   assign bus.o_of_reg     = (state == S_DONE) ? wb_dr  : 4'd0;
   assign bus.o_of_val     = (state == S_DONE) ? wb_val : 32'd0;

   tl45_mdu_iter u_iter (
      .clk       (i_clk),
      .reset_n   (i_reset_n),
      .clear     (bus.i_pipe_flush),
      .start     (start),
      .step      (state == S_BUSY),
      .op_is_div (op_is_div),
      .a         (bus.i_sr1_val),
      .b         (bus.i_sr2_val),
      .nxt_prod  (nxt_prod)
`ifdef TL45_MDU_DIV_EN
      ,
      .nxt_quo   (nxt_quo),
      .nxt_rem   (nxt_rem)
`endif
   );

   // Pick the writeback value for the latched opcode from the post-step datapath.
   always_comb begin
      result = nxt_prod;
`ifdef TL45_MDU_DIV_EN
      if (op_q == OP_DIVU)
         result = nxt_quo;
      else if (op_q == OP_REMU)
         result = nxt_rem;
`endif
   end

   // Sequencer: issue in IDLE, iterate in BUSY, hold the writeback in DONE while stalled.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n || bus.i_pipe_flush) begin
         state  <= S_IDLE;
         cnt    <= '0;
         op_q   <= OP_NOP;
         dr_q   <= '0;
         wb_dr  <= '0;
         wb_val <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (is_mdu_op) begin
                  op_q  <= bus.i_opcode;
                  dr_q  <= bus.i_dr;
                  cnt   <= '0;
                  state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (cnt == LAST) begin
                  cnt    <= '0;
                  state  <= S_DONE;
                  wb_dr  <= dr_q;
                  wb_val <= result;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            S_DONE: begin
               if (!bus.i_pipe_stall) begin
                  state  <= S_IDLE;
                  wb_dr  <= '0;
                  wb_val <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tl45_mdu.sv
// tb/tb_tl45_mdu.sv - self-checking bench for tl45_mdu (DIVU/REMU cases follow TL45_MDU_DIV_EN)
module tb_tl45_mdu;
   import tl45_pkg::*;

   typedef struct packed {
      logic [3:0]  dr;
      logic [31:0] val;
   } wb_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_total = 0;
   int   n_pass  = 0;
   int   n_fail  = 0;
   wb_t  sb[$];

   always #5 clk = ~clk;

   tl45_mdu_if bus ();

   tl45_mdu #(.ITERS(32)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      case (op)
         OP_MUL:  return a * b;
         OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         OP_REMU: return (b == 32'd0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [4:0] op, input logic [3:0] dr, input logic [31:0] a,
                        input logic [31:0] b);
      @(posedge clk);
      #1;
      bus.i_opcode  = op;
      bus.i_dr      = dr;
      bus.i_sr1_val = a;
      bus.i_sr2_val = b;
   endtask

   // Wait for o_pipe_stall to drop (bounded); returns stalled cycle count.
   task automatic wait_done(input string tag, output int cyc);
      cyc = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!bus.o_pipe_stall) break;
         cyc++;
         if (cyc == 10)
            check({tag, " busy fwd"}, 40'({bus.o_busy, bus.o_of_reg, bus.o_of_val}),
                  40'({1'b1, 36'd0}));
      end
   endtask

   task automatic pop_expect(output wb_t e);
      if (sb.size() == 0) begin
         check("scoreboard empty", 40'(1), 40'(0));
         e = '0;
      end else begin
         e = sb.pop_front();
      end
   endtask

   task automatic run_mdu(input string tag, input logic [4:0] op, input logic [3:0] dr,
                          input logic [31:0] a, input logic [31:0] b);
      int  cyc;
      wb_t e;
      issue(op, dr, a, b);
      sb.push_back({dr, model(op, a, b)});
      wait_done(tag, cyc);
      check({tag, " stall cycles"}, 40'(cyc), 40'(33));
      pop_expect(e);
      check({tag, " wb"}, 40'({bus.o_dr, bus.o_value}), 40'(e));
      check({tag, " fwd"}, 40'({bus.o_of_reg, bus.o_of_val}), 40'(e));
      @(posedge clk);
      #1 bus.i_opcode = OP_NOP;
      @(negedge clk);
      check({tag, " cleared"}, 40'({bus.o_busy, bus.o_dr, bus.o_value}), 40'(0));
   endtask

   initial begin
      int  cyc;
      wb_t e;

      rst_n            = 1'b0;
      bus.i_pipe_stall = 1'b0;
      bus.i_pipe_flush = 1'b0;
      bus.i_opcode     = OP_NOP;
      bus.i_dr         = 4'd0;
      bus.i_sr1_val    = 32'd0;
      bus.i_sr2_val    = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset state", 40'({bus.o_pipe_stall, bus.o_busy, bus.o_dr, bus.o_value}), 40'(0));
      check("reset fwd", 40'({bus.o_of_reg, bus.o_of_val}), 40'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;

      // pass-through of downstream stall and flush while idle
      bus.i_pipe_stall = 1'b1;
      bus.i_pipe_flush = 1'b1;
      @(negedge clk);
      check("stall/flush passthru", 40'({bus.o_pipe_stall, bus.o_pipe_flush}), 40'(2'b11));
      @(posedge clk);
      #1;
      bus.i_pipe_stall = 1'b0;
      bus.i_pipe_flush = 1'b0;

      run_mdu("mul 7x6", OP_MUL, 4'd3, 32'd7, 32'd6);
      run_mdu("mul overflow", OP_MUL, 4'd4, 32'hFFFF_FFFF, 32'd2);
      run_mdu("mul signed", OP_MUL, 4'd5, 32'hFFFF_FFFD, 32'd5);
      run_mdu("mul dr0", OP_MUL, 4'd0, 32'd11, 32'd13);
      for (int i = 0; i < 3; i++)
         run_mdu("mul random", OP_MUL, 4'($urandom_range(1, 15)), $urandom, $urandom);

`ifdef TL45_MDU_DIV_EN
      run_mdu("divu 100/7", OP_DIVU, 4'd6, 32'd100, 32'd7);
      run_mdu("remu 100%7", OP_REMU, 4'd7, 32'd100, 32'd7);
      run_mdu("divu by 0", OP_DIVU, 4'd8, 32'd5, 32'd0);
      run_mdu("remu by 0", OP_REMU, 4'd9, 32'd5, 32'd0);
      run_mdu("divu random", OP_DIVU, 4'd10, $urandom, 32'($urandom_range(1, 1000)));
      run_mdu("remu random", OP_REMU, 4'd11, $urandom, 32'($urandom_range(1, 1000)));
`else
      issue(OP_DIVU, 4'd6, 32'd100, 32'd7);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("divu nop", 40'({bus.o_pipe_stall, bus.o_busy, bus.o_dr, bus.o_value}),
               40'(0));
      end
      @(posedge clk);
      #1 bus.i_opcode = OP_NOP;
`endif

      // flush at BUSY cycle 10 aborts the MUL; the ADD behind it is not blocked
      issue(OP_MUL, 4'd12, 32'd9, 32'd9);
      repeat (10) @(posedge clk);
      #1;
      bus.i_pipe_flush = 1'b1;
      bus.i_opcode     = OP_ADD;
      @(negedge clk);
      check("flush passthru", 40'(bus.o_pipe_flush), 40'(1));
      @(posedge clk);
      #1 bus.i_pipe_flush = 1'b0;
      @(negedge clk);
      check("flush abort", 40'({bus.o_pipe_stall, bus.o_busy, bus.o_dr, bus.o_value}), 40'(0));
      repeat (3) @(negedge clk);
      check("add after flush", 40'({bus.o_pipe_stall, bus.o_busy}), 40'(0));

      // flush in IDLE suppresses the issue
      @(posedge clk);
      #1;
      bus.i_opcode     = OP_MUL;
      bus.i_pipe_flush = 1'b1;
      @(negedge clk);
      check("idle flush no stall", 40'(bus.o_pipe_stall), 40'(0));
      @(posedge clk);
      #1;
      bus.i_pipe_flush = 1'b0;
      bus.i_opcode     = OP_NOP;
      @(negedge clk);
      check("idle flush no issue", 40'(bus.o_busy), 40'(0));

      // reset in the middle of BUSY
      issue(OP_MUL, 4'd7, 32'd123, 32'd456);
      repeat (5) @(posedge clk);
      #1;
      rst_n        = 1'b0;
      bus.i_opcode = OP_NOP;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset mid busy", 40'({bus.o_pipe_stall, bus.o_busy, bus.o_dr, bus.o_value}),
            40'(0));

      // downstream stall for 3 edges in DONE holds writeback for 4 cycles, no re-issue
      issue(OP_MUL, 4'd9, 32'd1000, 32'd3000);
      sb.push_back({4'd9, model(OP_MUL, 32'd1000, 32'd3000)});
      wait_done("hold", cyc);
      check("hold stall cycles", 40'(cyc), 40'(33));
      pop_expect(e);
      check("hold done 0", 40'({bus.o_dr, bus.o_value}), 40'(e));
      bus.i_pipe_stall = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check("hold done n", 40'({bus.o_busy, bus.o_pipe_stall, bus.o_dr, bus.o_value}),
               40'({2'b11, e}));
      end
      bus.i_pipe_stall = 1'b0;
      @(posedge clk);
      #1 bus.i_opcode = OP_NOP;
      @(negedge clk);
      check("hold release", 40'({bus.o_busy, bus.o_dr, bus.o_value}), 40'(0));
      @(negedge clk);
      check("no reissue", 40'({bus.o_pipe_stall, bus.o_busy}), 40'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/tl45_mdu.md
# tl45_mdu

Iterative multiply/divide unit for the TL45 execute stage, sitting beside the ALU on the same decode→execute buffer. It detects MUL/DIVU/REMU opcodes, stalls earlier pipeline stages for 32 iteration cycles, then presents a registered writeback (`o_dr`/`o_value`) and a forwarding tap. It honours the stage-to-stage stall and flush protocol: stalls propagate backward and flushes abort in-flight work.

## Interface
- `ITERS`, default 32: iteration count; equals the operand width. Any other value is unsupported.
- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_reset_n` in 1: synchronous, active-low reset.
- `i_pipe_stall` in 1: downstream stall.
- `o_pipe_stall` out 1: `i_pipe_stall || mdu_busy`, combinational.
- `i_pipe_flush` in 1: flush request.
- `o_pipe_flush` out 1: equals `i_pipe_flush`, passed through.
- `i_opcode` in 5: decoded opcode. MUL=5'h03, DIVU=5'h04, REMU=5'h0F.
- `i_dr` in 4: destination register.
- `i_sr1_val` in 32: operand A (multiplicand or dividend).
- `i_sr2_val` in 32: operand B (multiplier or divisor).
- `o_dr` out 4: writeback register; 0 means no write.
- `o_value` out 32: writeback value.
- `o_of_reg` out 4: forwarding register, combinational.
- `o_of_val` out 32: forwarding value, combinational.
- `o_busy` out 1: state != IDLE; for debug and the hazard unit.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE:**
  - If `is_mdu_op` (opcode ∈ {MUL, DIVU, REMU}) and not `i_pipe_flush`, then `mdu_busy=1` in the same cycle.
  - At the edge: latch A, B, opcode and dr; clear the counter; go to BUSY.
  - Other opcodes: `o_dr` and `o_value` stay 0.
- **BUSY:** one iteration per cycle; `mdu_busy=1`. `i_pipe_stall` does not pause iteration.
  - MUL: shift-add. Result is the low 32 bits of A×B, which are the same for signed and unsigned operands.
  - DIVU/REMU: restoring division with a 33-bit partial remainder. Result is the quotient or the remainder.
- **BUSY→DONE:** at the edge where counter == ITERS-1. `o_dr` and `o_value` are registered at that edge.
- **DONE:**
  - `mdu_busy=0`, so the issuing instruction leaves the input buffer at the next edge.
  - The input opcode is ignored in DONE, so there is no re-issue.
  - If `i_pipe_stall` is high, DONE and the outputs hold. Otherwise go to IDLE and clear `o_dr`/`o_value` to 0.
- **Divide by zero:** quotient = 32'hFFFFFFFF; remainder = A. Covers both DIVU and REMU. No trap.
- **dr == 0:** the op still executes fully; writeback carries `o_dr=0`.
- **Forwarding:** in DONE, `o_of_reg=o_dr` and `o_of_val=o_value`; otherwise both are 0.
- **Flush (any state):** next state IDLE; `o_dr`/`o_value` become 0; the counter clears; the latched operands are discarded. Flush wins over completion in the same cycle.
- **Reset (`i_reset_n=0`, any state, including mid-BUSY):** state IDLE, counter 0, `o_dr=0`, `o_value=0`, internal accumulators 0.

## Timing
- The issue cycle is N, with the op presented in IDLE. `o_pipe_stall` is high during cycles N through N+32.
- DONE is cycle N+33, and the result is visible on `o_dr`/`o_value` in that cycle. Total latency is 33 edges.
- The next instruction can be accepted in IDLE at cycle N+34, or later if DONE was held by `i_pipe_stall`.
- Back-to-back MUL ops sustain 1 op per 34 cycles.
- Counter is 5 bits wide. It is compared against ITERS-1 and never wraps in BUSY.

## Configuration
- `TL45_MDU_DIV_EN` defined: the DIVU/REMU datapath and sequencing are compiled in.
- `TL45_MDU_DIV_EN` undefined:
  - Only MUL is recognised.
  - DIVU/REMU do not raise `mdu_busy`; they produce `o_dr=0`/`o_value=0` (NOP) and never stall.
  - The divider logic and the 33-bit remainder register are removed.

## Structure
- Shared package `tl45_pkg`:
  - opcode localparams (OP_MUL, OP_DIVU, OP_REMU, alongside the existing ALU opcodes);
  - the MDU state enum (IDLE/BUSY/DONE);
  - the divide-by-zero quotient constant.
- Sub-module `tl45_mdu_iter`: a single-step datapath holding the accumulator/remainder and the shift registers, with inputs `start`, `step` and `op_is_div`. The FSM, counter and pipe handshake stay in `tl45_mdu`.

## Test plan
- MUL: A=7, B=6, dr=3 → stall high for 33 cycles; in DONE, `o_dr=3`, `o_value=42`; 0 the next cycle.
- MUL overflow: A=32'hFFFFFFFF, B=2 → `o_value=32'hFFFFFFFE`. Signed MUL: A=-3, B=5 → `o_value=32'hFFFFFFF1`.
- DIVU: A=100, B=7 → quotient 14. REMU with the same operands → 2. DIVU with A=5, B=0 → 32'hFFFFFFFF. REMU with A=5, B=0 → 5.
- Flush pulsed at BUSY cycle 10 of MUL → state IDLE next cycle; `o_dr=0`; stall drops; a following ADD is not blocked.
- `i_reset_n` low mid-BUSY → all outputs 0 and IDLE after the edge. Downstream `i_pipe_stall` held for 3 cycles in DONE → `o_dr`/`o_value` held for 4 cycles, no re-issue.
- Build without `TL45_MDU_DIV_EN`: DIVU presented → `o_pipe_stall` stays 0 and `o_dr=0`. MUL still works (42 case).
